// File: rtl/ram_bank_scheduler.sv
// Sequences the block-RAM banks behind the UART receiver: packs bytes into words
// and fills the banks bank-major, then serves a pipelined fixed-latency read port.
module ram_bank_scheduler #(
  parameter int unsigned N_BANKS = 4,
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                         uart_clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_rearm,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_valid,
  output logic [N_BANKS-1:0]           o_bank_we,
  output logic [ADDR_W-1:0]            o_addr,
  output logic [DATA_W-1:0]            o_wdata,
  input  logic [N_BANKS*DATA_W-1:0]    i_bank_rdata,
  input  logic                         i_rd_req,
  input  logic [$clog2(N_BANKS)-1:0]   i_rd_bank,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic                         o_rd_ready,
  output logic                         o_rd_valid,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_err,
  output logic [1:0]                   o_state,
  output logic                         o_load_done,
  output logic                         o_overrun
);

  localparam int unsigned BANK_W = $clog2(N_BANKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         pack_q, pack_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                load_full_q, load_full_d;
  logic [N_BANKS-1:0]  bank_we_q, bank_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                p_valid_q, p_valid_d;
  logic [BANK_W-1:0]   p_bank_q, p_bank_d;
  logic                p_err_q, p_err_d;
  logic                rd_valid_q, rd_valid_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic                rd_err_q, rd_err_d;
  logic                overrun_q, overrun_d;
  logic                load_done_q, load_done_d;
  logic                rd_ready_c;
  logic [DATA_W-1:0]   rd_data_c;

  // Requests are blocked in the rearm cycle so nothing new enters the pipe.
  assign rd_ready_c = (state_q == S_READY) && !i_rearm;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    bank_d      = bank_q;
    waddr_d     = waddr_q;
    load_full_d = load_full_q;
    bank_we_d   = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    p_valid_d   = 1'b0;
    p_bank_d    = p_bank_q;
    p_err_d     = 1'b0;
    rd_valid_d  = p_valid_q;
    rd_bank_d   = p_bank_q;
    rd_err_d    = p_err_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (i_byte_valid) overrun_d = 1'b1;
        if (i_start)      state_d   = S_LOAD;
      end
      S_LOAD: begin
        // One idle cycle after the final write, then hand over to READY.
        if (load_full_q) begin
          state_d     = S_READY;
          load_full_d = 1'b0;
        end else if (i_byte_valid) begin
          if (lane_q == 2'd3) begin
            bank_we_d = N_BANKS'(1) << bank_q;
            addr_d    = waddr_q;
            wdata_d   = {i_byte, pack_q};
            lane_d    = 2'd0;
            if (waddr_q == ADDR_W'(DEPTH - 1)) begin
              waddr_d = '0;
              bank_d  = bank_q + BANK_W'(1);
              if (bank_q == BANK_W'(N_BANKS - 1)) load_full_d = 1'b1;
            end else begin
              waddr_d = waddr_q + ADDR_W'(1);
            end
          end else begin
            pack_d[8*lane_q +: 8] = i_byte;
            lane_d                = lane_q + 2'd1;
          end
        end
      end
      S_READY: begin
        if (i_rearm) begin
          state_d     = S_LOAD;
          lane_d      = 2'd0;
          pack_d      = '0;
          bank_d      = '0;
          waddr_d     = '0;
          load_full_d = 1'b0;
          overrun_d   = 1'b0;
        end else begin
          if (i_byte_valid) overrun_d = 1'b1;
          if (i_rd_req && rd_ready_c) begin
            addr_d    = i_rd_addr;
            p_valid_d = 1'b1;
            p_bank_d  = i_rd_bank;
            p_err_d   = {1'b0, i_rd_addr} >= (ADDR_W + 1)'(DEPTH);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_done_d = (state_d == S_READY);
  end

  always_ff @(posedge uart_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'd0;
      pack_q      <= '0;
      bank_q      <= '0;
      waddr_q     <= '0;
      load_full_q <= 1'b0;
      bank_we_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      p_valid_q   <= 1'b0;
      p_bank_q    <= '0;
      p_err_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_bank_q   <= '0;
      rd_err_q    <= 1'b0;
      overrun_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      bank_q      <= bank_d;
      waddr_q     <= waddr_d;
      load_full_q <= load_full_d;
      bank_we_q   <= bank_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      p_valid_q   <= p_valid_d;
      p_bank_q    <= p_bank_d;
      p_err_q     <= p_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_bank_q   <= rd_bank_d;
      rd_err_q    <= rd_err_d;
      overrun_q   <= overrun_d;
      load_done_q <= load_done_d;
    end
  end

  // Synchronous RAM output arrives the cycle after o_addr; select the pipelined bank.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < N_BANKS; k++) begin
      if (rd_bank_q == BANK_W'(k)) rd_data_c = i_bank_rdata[k*DATA_W +: DATA_W];
    end
    if (!rd_valid_q || rd_err_q) rd_data_c = '0;
  end

  assign o_bank_we   = bank_we_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_rd_ready  = rd_ready_c;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_c;
  assign o_rd_err    = rd_err_q;
  assign o_state     = state_q;
  assign o_load_done = load_done_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_ram_bank_scheduler.sv
// Directed bench for ram_bank_scheduler with a behavioural four-bank synchronous RAM.
module tb_ram_bank_scheduler;

  logic         uart_clk;
  logic         reset;
  logic         i_start;
  logic         i_rearm;
  logic [7:0]   i_byte;
  logic         i_byte_valid;
  logic [3:0]   o_bank_we;
  logic [3:0]   o_addr;
  logic [31:0]  o_wdata;
  logic [127:0] bank_rdata;
  logic         i_rd_req;
  logic [1:0]   i_rd_bank;
  logic [3:0]   i_rd_addr;
  logic         o_rd_ready;
  logic         o_rd_valid;
  logic [31:0]  o_rd_data;
  logic         o_rd_err;
  logic [1:0]   o_state;
  logic         o_load_done;
  logic         o_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4][16];

  ram_bank_scheduler dut (
    .uart_clk     (uart_clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_rearm      (i_rearm),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_bank_we    (o_bank_we),
    .o_addr       (o_addr),
    .o_wdata      (o_wdata),
    .i_bank_rdata (bank_rdata),
    .i_rd_req     (i_rd_req),
    .i_rd_bank    (i_rd_bank),
    .i_rd_addr    (i_rd_addr),
    .o_rd_ready   (o_rd_ready),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_rd_err     (o_rd_err),
    .o_state      (o_state),
    .o_load_done  (o_load_done),
    .o_overrun    (o_overrun)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  // Read-first synchronous RAM, one instance per bank, shared address.
  always @(posedge uart_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (o_bank_we[k]) mem[k][o_addr] <= o_wdata;
      bank_rdata[k*32 +: 32] <= mem[k][o_addr];
    end
  end

  typedef struct {
    logic [1:0]  bank;
    logic [3:0]  addr;
    logic        err;
    logic [31:0] data;
  } rd_vec_t;

  localparam int NV = 8;
  rd_vec_t vec [NV];

  task automatic step();
    @(posedge uart_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    vec[0] = '{2'd2, 4'd3,  1'b0, 32'h5F5E5D5C};
    vec[1] = '{2'd3, 4'd9,  1'b0, 32'h9F9E9D9C};
    vec[2] = '{2'd0, 4'd0,  1'b0, 32'h03020100};
    vec[3] = '{2'd1, 4'd0,  1'b0, 32'h2B2A2928};
    vec[4] = '{2'd1, 4'd12, 1'b1, 32'h00000000};
    vec[5] = '{2'd1, 4'd9,  1'b0, 32'h4F4E4D4C};
    vec[6] = '{2'd3, 4'd15, 1'b1, 32'h00000000};
    vec[7] = '{2'd0, 4'd9,  1'b0, 32'h27262524};

    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 16; a++) mem[k][a] = 32'h0;
    bank_rdata   = '0;
    reset        = 1'b1;
    i_start      = 1'b0;
    i_rearm      = 1'b0;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    i_rd_req     = 1'b0;
    i_rd_bank    = 2'd0;
    i_rd_addr    = 4'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_state",    32'(o_state),    32'd0);
    chk("rst_we",       32'(o_bank_we),  32'd0);
    chk("rst_addr",     32'(o_addr),     32'd0);
    chk("rst_wdata",    o_wdata,         32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_rd_err",   32'(o_rd_err),   32'd0);
    chk("rst_rd_data",  o_rd_data,       32'd0);
    chk("rst_done",     32'(o_load_done), 32'd0);
    chk("rst_overrun",  32'(o_overrun),  32'd0);
    chk("rst_rd_ready", 32'(o_rd_ready), 32'd0);

    // Byte in IDLE sets overrun, no write
    send_byte(8'h99);
    chk("idle_overrun", 32'(o_overrun), 32'd1);
    chk("idle_we",      32'(o_bank_we), 32'd0);
    chk("idle_state",   32'(o_state),   32'd0);

    // Reset after a partial word discards it
    pulse_start();
    chk("start_state", 32'(o_state), 32'd1);
    send_byte(8'hEE);
    send_byte(8'hFF);
    do_reset();
    chk("midrst_state",   32'(o_state),   32'd0);
    chk("midrst_overrun", 32'(o_overrun), 32'd0);
    chk("midrst_we",      32'(o_bank_we), 32'd0);
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("w0_we_early", 32'(o_bank_we), 32'd0);
    send_byte(8'h44);
    chk("w0_we",    32'(o_bank_we), 32'b0001);
    chk("w0_addr",  32'(o_addr),    32'd0);
    chk("w0_wdata", o_wdata,        32'h44332211);
    step();
    chk("w0_we_pulse", 32'(o_bank_we), 32'd0);

    // Full load: byte n = n, 40 words bank-major
    do_reset();
    pulse_start();
    for (int n = 0; n < 160; n++) begin
      i_byte       = 8'(n);
      i_byte_valid = 1'b1;
      step();
      if ((n % 4) == 3) begin
        chk("load_we",    32'(o_bank_we), 32'(4'b0001 << ((n / 4) / 10)));
        chk("load_addr",  32'(o_addr),    32'((n / 4) % 10));
        chk("load_wdata", o_wdata,        {8'(n), 8'(n - 1), 8'(n - 2), 8'(n - 3)});
        if (n == 43) chk("bank1_addr0", o_wdata, 32'h2B2A2928);
      end else begin
        chk("load_we_idle", 32'(o_bank_we), 32'd0);
      end
    end
    i_byte_valid = 1'b0;
    chk("last_we",     32'(o_bank_we), 32'b1000);
    chk("last_addr",   32'(o_addr),    32'd9);
    chk("last_state",  32'(o_state),   32'd1);
    chk("last_done",   32'(o_load_done), 32'd0);
    step();
    chk("ready_state", 32'(o_state),    32'd2);
    chk("ready_done",  32'(o_load_done), 32'd1);
    chk("ready_we",    32'(o_bank_we),  32'd0);
    chk("ready_rdy",   32'(o_rd_ready), 32'd1);

    // Back-to-back reads: vector i accepted in cycle i, data in cycle i+2
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        i_rd_req  = 1'b1;
        i_rd_bank = vec[i].bank;
        i_rd_addr = vec[i].addr;
      end else begin
        i_rd_req = 1'b0;
      end
      step();
      if (i < NV) chk("rd_addr", 32'(o_addr), 32'(vec[i].addr));
      if (i >= 1) begin
        chk("rd_valid", 32'(o_rd_valid), 32'd1);
        chk("rd_err",   32'(o_rd_err),   32'(vec[i-1].err));
        chk("rd_data",  o_rd_data,       vec[i-1].data);
      end else begin
        chk("rd_valid_lat", 32'(o_rd_valid), 32'd0);
      end
    end
    step();
    chk("rd_drain", 32'(o_rd_valid), 32'd0);

    // Byte in READY sets overrun
    send_byte(8'h55);
    chk("ready_overrun", 32'(o_overrun), 32'd1);
    chk("ready_ovr_we",  32'(o_bank_we), 32'd0);
    chk("ready_ovr_st",  32'(o_state),   32'd2);

    // Rearm with a coincident byte and read request
    i_rearm      = 1'b1;
    i_byte       = 8'h77;
    i_byte_valid = 1'b1;
    i_rd_req     = 1'b1;
    i_rd_bank    = 2'd0;
    i_rd_addr    = 4'd5;
    #1;
    chk("rearm_rdy", 32'(o_rd_ready), 32'd0);
    step();
    i_rearm      = 1'b0;
    i_byte_valid = 1'b0;
    i_rd_req     = 1'b0;
    chk("rearm_state",   32'(o_state),     32'd1);
    chk("rearm_overrun", 32'(o_overrun),   32'd0);
    chk("rearm_done",    32'(o_load_done), 32'd0);
    step();
    chk("rearm_no_rd", 32'(o_rd_valid), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    chk("rearm_we",      32'(o_bank_we), 32'b0001);
    chk("rearm_addr",    32'(o_addr),    32'd0);
    chk("rearm_wdata",   o_wdata,        32'hDDCCBBAA);
    chk("rearm_ovr_end", 32'(o_overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_scheduler.md
Name: ram_bank_scheduler

Overview:
- Sequences the four 32-bit block-RAM banks behind the UART receiver.
- LOAD phase: packs received bytes into 32-bit words and writes them to the banks in bank-major order.
- READY phase: arbitrates a pipelined read port that the accelerator core uses to fetch words by (bank, address).
- Owns the shared RAM address/write-enable lines, so no other logic drives the banks.

Parameters:
- N_BANKS, 4, number of RAM banks (power of two).
- DEPTH, 10, words per bank used.
- ADDR_W, 4, bank address width; DEPTH <= 2**ADDR_W.
- DATA_W, 32, word width; always 4 bytes.

Ports:
- uart_clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- i_start  in  1  pulse; leaves IDLE and begins LOAD.
- i_rearm  in  1  pulse; in READY, returns to LOAD and restarts filling from bank 0, address 0.
- i_byte  in  8  received UART byte.
- i_byte_valid  in  1  single-cycle strobe qualifying i_byte.
- o_bank_we  out  N_BANKS  one-hot write enable, one per bank.
- o_addr  out  ADDR_W  shared address to all banks (registered).
- o_wdata  out  DATA_W  shared write data (registered).
- i_bank_rdata  in  N_BANKS*DATA_W  concatenated bank douta; bank k occupies bits [k*32+:32].
- i_rd_req  in  1  read request.
- i_rd_bank  in  $clog2(N_BANKS)  requested bank.
- i_rd_addr  in  ADDR_W  requested address.
- o_rd_ready  out  1  high only in READY; a request is accepted when i_rd_req && o_rd_ready.
- o_rd_valid  out  1  read data valid.
- o_rd_data  out  DATA_W  read data.
- o_rd_err  out  1  with o_rd_valid; the address was out of range.
- o_state  out  2  0 IDLE, 1 LOAD, 2 READY.
- o_load_done  out  1  high while in READY.
- o_overrun  out  1  sticky; a byte arrived outside LOAD.

Behaviour:
- Reset values: state IDLE. All outputs 0: o_bank_we, o_addr, o_wdata, o_rd_valid, o_rd_data, o_rd_err, o_load_done, o_overrun. Byte lane counter, bank index and write address are also 0.
- RAM contents are not cleared by reset.
- IDLE -> LOAD on i_start. In IDLE, i_byte_valid sets o_overrun and the byte is dropped.
- LOAD packing:
  - Each i_byte_valid stores the byte at lane = byte counter, little-endian (first byte lands in [7:0]).
  - On the 4th byte, the next edge registers o_wdata = packed word and asserts o_bank_we[bank] for exactly 1 cycle, with o_addr = waddr.
- Write order: bank 0 addresses 0..DEPTH-1, then bank 1, and so on.
- After the write of bank N_BANKS-1, address DEPTH-1, the state moves to READY on the following edge. o_load_done = 1 from that cycle onward.
- Total load is N_BANKS*DEPTH words (default 40 words = 160 bytes).
- A partial word (fewer than 4 bytes) is held indefinitely; there is no timeout.
- READY:
  - A request accepted in cycle T drives o_addr = i_rd_addr in T+1. The bank select is pipelined alongside it.
  - The RAM has 1-cycle latency, so in T+2: o_rd_valid = 1 and o_rd_data = i_bank_rdata slice of the pipelined bank.
  - Back-to-back requests are accepted every cycle; throughput is 1 word/cycle at fixed latency 2.
- Out of range: i_rd_addr >= DEPTH is still accepted and issued. At T+2, o_rd_data = 0 and o_rd_err = 1.
- o_bank_we is always 0 in READY and IDLE.
- Bytes received in READY set o_overrun and are dropped.
- i_rearm in READY:
  - Next state is LOAD; bank, waddr and lane are cleared; o_load_done drops.
  - o_overrun is cleared.
  - Reads accepted before i_rearm still complete their pipeline.
  - i_rd_req in the i_rearm cycle is not accepted, because o_rd_ready is forced low that cycle.
- Simultaneous events:
  - i_rearm with i_byte_valid: rearm wins and the byte is dropped without setting o_overrun.
  - i_start outside IDLE is ignored.
  - i_rearm outside READY is ignored.
- Reset mid-LOAD or mid-read: returns to IDLE immediately and the pending partial word is discarded. No write or o_rd_valid is issued after the reset edge.

Test Plan:
- Reset, i_start, then send bytes 0x11,0x22,0x33,0x44 -> exactly one 1-cycle o_bank_we = 4'b0001, o_addr = 0, o_wdata = 32'h44332211.
- Send 160 bytes, byte n = n[7:0] -> 40 writes. Bank 1 address 0 gets 32'h2B2A2928. The state is READY one cycle after the last write, with o_load_done = 1.
- In READY, back-to-back requests (bank 2, addr 3) then (bank 3, addr 9), with a RAM model -> o_rd_valid in T+2 and T+3 with the matching words.
- i_rd_addr = 12 in READY -> o_rd_valid = 1, o_rd_err = 1, o_rd_data = 0 at T+2.
- Byte strobes in IDLE and in READY -> o_overrun = 1 and no o_bank_we. i_rearm -> o_overrun = 0, state LOAD, next word written to bank 0 address 0.
- Reset after 2 bytes of a word, then i_start and 4 new bytes -> the written word contains only the new 4 bytes, at bank 0 address 0.
